uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receive engine, the receive-side counterpart of the team's UART transmitter. It recovers 5–9 data bits, LSB first, from the asynchronous `rx` line. It checks optional even/odd parity and 1 or 2 stop bits, and presents each frame on a parallel bus with a one-cycle valid strobe and error flags. It sits between the pad/loopback line and the frame consumer; the line format configuration is shared with the transmitter.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit period, ≥1. Use 1 for same-clock lockstep with the transmitter.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `parity`  in  1  1 = a parity bit follows the data bits
- `parity_type`  in  1  0 = even (parity bit = XOR of data), 1 = odd (parity bit = XNOR of data)
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits
- `frame_length`  in  4  data bits per frame; 5..9 used, <5 clamps to 5, >9 clamps to 9
- `frame_out`  out  9  received data, bit 0 = first bit received, bits ≥ length are zero
- `data_valid`  out  1  one-cycle pulse, `frame_out`/error flags valid
- `parity_error`  out  1  parity mismatch on the delivered frame (0 when parity disabled)
- `framing_error`  out  1  a sampled stop bit was 0 on the delivered frame
- `busy`  out  1  high in every state except IDLE

## Operation
- `rx` passes through a 2-flop synchronizer; the FSM sees only `rx_s`.
- `parity`, `parity_type`, `stop_bits` and clamped `frame_length` are latched when a start is detected. Changes mid-frame have no effect.
- HALF = (CLKS_PER_BIT−1)/2, integer division. A bit counter counts 0..CLKS_PER_BIT−1; an index counter counts data bits 0..len−1.
- IDLE: `rx_s`=0 → START, timer cleared.
- START: at HALF cycles after detection, re-sample `rx_s`. If it is 1 (glitch) → IDLE, no output. If it is 0 → DATA. With HALF=0, the detection cycle is itself the check.
- DATA: every CLKS_PER_BIT cycles, shift `rx_s` into shift register bit [index]. After bit len−1 → PARITY if `parity` is set, else STOP1.
- PARITY: sample one bit and compare it against the XOR of the received data (XNOR if odd) → STOP1.
- STOP1: sample the bit. 0 sets framing flag. → STOP2 if `stop_bits` is set, else DONE.
- STOP2: sample the bit; 0 sets framing flag → DONE.
- DONE (1 cycle): register `frame_out`, `parity_error`, `framing_error`; pulse `data_valid`. Framing flag clear → IDLE. Framing flag set → WAIT_IDLE.
- WAIT_IDLE: remain until `rx_s`=1 (break/stuck-low line), then → IDLE. No new start is accepted while in WAIT_IDLE.
- Frames with errors are still delivered; the consumer decides whether to drop them.
- No backpressure: the consumer must take `frame_out` on the `data_valid` cycle. Outputs hold until the next DONE.

## Timing
- Reset values: `frame_out`=0, `data_valid`=0, `parity_error`=0, `framing_error`=0, `busy`=0, FSM=IDLE, all counters 0.
- t0 = first cycle `rx_s`=0 in IDLE, which is 2 cycles after `rx` falls.
- Start check is at t0+HALF.
- Bit k is sampled at t0+HALF+CLKS_PER_BIT·(k+1). Bits are counted from 0 = first data bit, continuing through the parity and stop bits.
- `data_valid` is high the cycle after the last stop-bit sample.
- IDLE accepts a new start on the cycle after DONE. Back-to-back frames with one stop bit must be received without loss.
- `busy` rises at t0+1 and falls the cycle after DONE, or after WAIT_IDLE exits.
- `rst` mid-frame: all outputs return to reset values immediately, and the partial frame is discarded. After release, a frame already in progress is only picked up if its start is seen; a line held low is treated as a start.

## Structure
- Shared `uart_pkg`: FSM state encodings (IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, WAIT_IDLE), `FRAME_MIN`=5, `FRAME_MAX`=9, parity-type constants. The transmitter also uses this package.
- One sub-module, `uart_rx_sync`: 2-flop synchronizer with a reset value of 1. Everything else is inline in `uart_receiver`.

## Test plan
- CLKS_PER_BIT=16, len=8, no parity, 1 stop; send 0xA5 → exactly one `data_valid`, `frame_out`=9'h0A5, both error flags 0.
- len=7, even parity; send 0x55 with parity bit 1 → `frame_out`=9'h055, `parity_error`=1. Send it again with parity bit 0 → `parity_error`=0.
- `rx` pulled low for 4 cycles, then high → no `data_valid`, `busy` returns to 0 within 9 cycles.
- len=8; send 0x3C with stop bit 0, hold `rx` low for 40 cycles, then send 0x81 → first frame 9'h03C with `framing_error`=1; second frame 9'h081 with no errors.
- len=9, odd parity, 2 stop bits; send 0x1FF back-to-back twice → two pulses, each 9'h1FF, no errors. Then assert `rst` mid-third-frame → outputs reset, no third pulse.
- CLKS_PER_BIT=1, driven by the team transmitter with len=6, parity, `frame_to_transmit`=0x2B → received `frame_out` matches the low 6 bits, `parity_error`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// Holds the FSM state encoding, frame-length limits, parity-type constants,
// the latched line-format record and a frame-length clamp helper.
package uart_pkg;

  localparam int unsigned FRAME_MIN = 5;
  localparam int unsigned FRAME_MAX = 9;
  localparam int unsigned LEN_W     = 4;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_DONE,
    ST_WAIT_IDLE
  } uart_state_e;

  // Line format captured at start-bit detection
  typedef struct packed {
    logic             parity;
    logic             parity_type;
    logic             stop_bits;
    logic [LEN_W-1:0] len;
  } uart_cfg_t;

  // Force the data-bit count into the supported 5..9 range
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len < LEN_W'(FRAME_MIN)) return LEN_W'(FRAME_MIN);
    if (len > LEN_W'(FRAME_MAX)) return LEN_W'(FRAME_MAX);
    return len;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver bus: serial line and line-format configuration towards the
// receiver, parallel frame with strobe, error flags and busy back out.
//   master : line/config driver and frame consumer
//   slave  : uart_receiver
interface uart_receiver_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 parity;
  logic                 parity_type;
  logic                 stop_bits;
  logic [LEN_W-1:0]     frame_length;
  logic [FRAME_MAX-1:0] frame_out;
  logic                 data_valid;
  logic                 parity_error;
  logic                 framing_error;
  logic                 busy;

  modport master (
    output rx, parity, parity_type, stop_bits, frame_length,
    input  frame_out, data_valid, parity_error, framing_error, busy
  );

  modport slave (
    input  rx, parity, parity_type, stop_bits, frame_length,
    output frame_out, data_valid, parity_error, framing_error, busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle (high) line is assumed while in reset.
//   clk, rst : clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// UART receive engine: recovers 5..9 LSB-first data bits, checks optional
// even/odd parity and 1 or 2 stop bits, and presents each frame with a
// one-cycle data_valid strobe and error flags.
//   CLKS_PER_BIT : clk cycles per bit period (>= 1)
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : uart_receiver_if.slave (line, format, frame, flags, busy)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_receiver_if.slave  bus
);
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // START is entered on the cycle after detection, so the check fires one count early
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((HALF > 0) ? HALF - 1 : 0);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [FRAME_MAX-1:0] shift_q, shift_d;
  uart_cfg_t            cfg_q, cfg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [FRAME_MAX-1:0] frame_out_q, frame_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 framing_error_q, framing_error_d;
  logic                 busy_q, busy_d;
  logic                 bit_tick;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  assign bit_tick = (cnt_q == CNT_LAST);

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shift_d         = shift_q;
    cfg_d           = cfg_q;
    perr_d          = perr_q;
    ferr_d          = ferr_q;
    frame_out_d     = frame_out_q;
    data_valid_d    = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cfg_d   = '{parity:      bus.parity,
                      parity_type: bus.parity_type,
                      stop_bits:   bus.stop_bits,
                      len:         clamp_len(bus.frame_length)};
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          // With HALF = 0 the detection cycle doubles as the start check
          state_d = (HALF == 0) ? ST_DATA : ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == cfg_q.len - LEN_W'(1)) begin
            idx_d   = '0;
            state_d = cfg_q.parity ? ST_PARITY : ST_STOP1;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          // Unused shift bits are zero, so reducing the whole register is safe
          perr_d  = rx_s ^ (^shift_q) ^ (cfg_q.parity_type == PARITY_ODD);
          state_d = ST_STOP1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP1: begin
        if (bit_tick) begin
          cnt_d   = '0;
          ferr_d  = ferr_q | ~rx_s;
          state_d = cfg_q.stop_bits ? ST_STOP2 : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP2: begin
        if (bit_tick) begin
          cnt_d   = '0;
          ferr_d  = ferr_q | ~rx_s;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ferr_q ? ST_WAIT_IDLE : ST_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Load the output registers on entry to DONE so the strobe occupies the DONE cycle
    if (state_d == ST_DONE) begin
      frame_out_d     = shift_d;
      parity_error_d  = perr_d;
      framing_error_d = ferr_d;
      data_valid_d    = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      cfg_q           <= '0;
      perr_q          <= 1'b0;
      ferr_q          <= 1'b0;
      frame_out_q     <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      cfg_q           <= cfg_d;
      perr_q          <= perr_d;
      ferr_q          <= ferr_d;
      frame_out_q     <= frame_out_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.frame_out     = frame_out_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = busy_q;
endmodule
